// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner with per-slot anti-ghost blanking and frame-synchronous shadow capture.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic [3:0]  dp_in,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_tick
);
    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);

    logic [PW-1:0] p_q, p_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_digits_q, shadow_digits_d;
    logic [3:0]    shadow_dp_q, shadow_dp_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          p_wrap, frame_wrap, lit;
    logic [3:0]    nib;
    logic [3:0]    digit_blank;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // A digit is suppressed only when it and every more-significant digit carry neither a value nor a point.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lz
            if (gi == 0) begin : g_d0
                assign digit_blank[gi] = 1'b0;
            end else begin : g_dn
`ifdef SEG7_LZ_BLANK_EN
                assign digit_blank[gi] = (shadow_digits_q[15:gi*4] == '0) && (shadow_dp_q[3:gi] == '0);
`else
                assign digit_blank[gi] = 1'b0;
`endif
            end
        end
    endgenerate

    always_comb begin
        p_wrap          = (p_q == P_LAST);
        frame_wrap      = p_wrap && (idx_q == 2'd3);
        p_d             = p_wrap ? '0 : p_q + 1'b1;
        idx_d           = p_wrap ? idx_q + 2'd1 : idx_q;
        shadow_digits_d = frame_wrap ? digits_in : shadow_digits_q;
        shadow_dp_d     = frame_wrap ? dp_in : shadow_dp_q;
        nib             = shadow_digits_q[idx_q*4 +: 4];
        lit             = enable && (p_q >= P_BLANK) && !digit_blank[idx_q];
        an_d            = 4'b1111;
        seg_d           = 7'b1111111;
        dp_d            = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            seg_d       = glyph(nib);
            dp_d        = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q             <= '0;
            idx_q           <= '0;
            shadow_digits_q <= '0;
            shadow_dp_q     <= '0;
            an_q            <= 4'b1111;
            seg_q           <= 7'b1111111;
            dp_q            <= 1'b1;
        end else begin
            p_q             <= p_d;
            idx_q           <= idx_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_dp_q     <= shadow_dp_d;
            an_q            <= an_d;
            seg_q           <= seg_d;
            dp_q            <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_wrap;
endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: expected lit slots are queued up front and a monitor matches every lit run of the display.
module tb_seg7_scan;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        enable;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    seg7_scan #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .enable(enable),
        .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    slot_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    logic [6:0] glyph [0:15];
    initial begin
        glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
        glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
        glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
        glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [15:0] d, input logic [3:0] dpv);
        slot_t e;
        bit    blank;
        for (int n = 0; n < 4; n++) begin
            blank = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
            if (n > 0 && (d >> (4 * n)) == 16'h0 && (dpv >> n) == 4'h0) blank = 1'b1;
`endif
            if (!blank) begin
                e.an  = 4'hF & ~(4'b0001 << n);
                e.seg = glyph[d[n*4 +: 4]];
                e.dp  = ~dpv[n];
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: a lit run is one transaction; its anode, glyph, point and length are scored on completion.
    int         run_len = 0;
    logic [3:0] run_an;
    logic [6:0] run_seg;
    logic       run_dp;
    bit         run_bad;
    int         cyc = 0;
    int         last_tick = -1;

    task automatic close_run();
        slot_t e;
        $display("slot an=%b seg=%b dp=%b len=%0d", run_an, run_seg, run_dp, run_len);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_run: got an=%b seg=%b required none", run_an, run_seg);
        end else begin
            e = exp_q.pop_front();
            check("run_an", 32'(run_an), 32'(e.an));
            check("run_seg", 32'(run_seg), 32'(e.seg));
            check("run_dp", 32'(run_dp), 32'(e.dp));
            check("run_len", run_len, 6);
            check("run_stable", 32'(run_bad), 0);
        end
        run_len = 0;
    endtask

    always @(negedge clk) begin
        if (rst || !mon_en) begin
            run_len   = 0;
            last_tick = -1;
        end else begin
            if (frame_tick) begin
                if (last_tick >= 0) check("tick_period", cyc - last_tick, 32);
                last_tick = cyc;
            end
            if (an != 4'hF) begin
                if (run_len > 0 && an != run_an) close_run();
                if (run_len == 0) begin
                    run_an  = an;
                    run_seg = seg;
                    run_dp  = dp;
                    run_bad = 1'b0;
                end else if (seg !== run_seg || dp !== run_dp) begin
                    run_bad = 1'b1;
                end
                run_len++;
            end else begin
                check("blank_segdp", {24'h0, dp, seg}, 32'hFF);
                if (run_len > 0) close_run();
            end
        end
        cyc++;
    end

    task automatic wait_tick(output int lit_cnt);
        bit seen = 1'b0;
        lit_cnt = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (an != 4'hF) lit_cnt++;
            if (frame_tick) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no frame_tick required one within 100 cycles");
        end
    endtask

    initial begin
        int lit;
        rst       = 1'b1;
        digits_in = 16'h1234;
        dp_in     = 4'b0000;
        enable    = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_reset_lit", 32'(an), 32'hD);
        rst = 1'b1;
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 1);
        check("rst_tick", 32'(frame_tick), 0);
        repeat (2) @(negedge clk);
        check("rst_hold_an", 32'(an), 32'hF);

        push_frame(16'h0000, 4'b0000);
        push_frame(16'h1234, 4'b0000);
        push_frame(16'hABCD, 4'b0000);
        push_frame(16'h0052, 4'b0010);
        push_frame(16'h0000, 4'b0000);
        mon_en = 1'b1;
        rst    = 1'b0;

        @(negedge clk); check("rel_c1_an", 32'(an), 32'hF);
        @(negedge clk); check("rel_c2_an", 32'(an), 32'hF);
        @(negedge clk); check("rel_c3_an", 32'(an), 32'hE);
        check("rel_c3_seg", 32'(seg), 32'h40);

        wait_tick(lit);
        repeat (16) @(negedge clk);
        digits_in = 16'hABCD;
        wait_tick(lit);
        repeat (16) @(negedge clk);
        digits_in = 16'h0052;
        dp_in     = 4'b0010;
        wait_tick(lit);
        repeat (16) @(negedge clk);
        digits_in = 16'h0000;
        dp_in     = 4'b0000;
        wait_tick(lit);
        @(negedge clk);
        enable = 1'b0;
        wait_tick(lit);
        check("disabled_lit_cycles", lit, 0);
        @(negedge clk);
        enable = 1'b1;
        wait_tick(lit);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        check("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
